menu_loader: RTL and testbench

MENU_LOADER -- requirements
Module: menu_loader

---
 rtl/menu_loader.sv | 186 ++++++++++++++++++
 tb/tb_menu_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/menu_loader.sv
// Menu image loader: finds SYNC_BYTE, reads a 20-bit big-endian pixel count,
// writes one 6-bit pixel per data byte and verifies a trailing XOR checksum.
module menu_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_PIXELS     = 104796,
  parameter int         TIMEOUT_CYCLES = 6500000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [19:0] wr_addr,
  output logic [5:0]  wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int               GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [19:0]      MAX_N    = 20'(MAX_PIXELS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SYNC  = 4'd1,
    HDR0  = 4'd2,
    HDR1  = 4'd3,
    HDR2  = 4'd4,
    DATA  = 4'd5,
    CHECK = 4'd6,
    DONE  = 4'd7,
    ERROR = 4'd8
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [19:0]      count_r;
  logic [19:0]      index_r;
  logic [7:0]       xor_r;
  logic [GAP_W-1:0] gap_r;
  logic             timeout_s;
  logic [19:0]      hdr_n_s;
  logic [19:0]      wr_addr_r;
  logic [5:0]       wr_data_r;
  logic             wr_en_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  function automatic logic is_busy(input state_t s);
    case (s)
      IDLE, DONE, ERROR: return 1'b0;
      default:           return 1'b1;
    endcase
  endfunction

  // Next-state decode; a byte arriving on the last allowed cycle beats the timeout.
  always_comb begin
    state_next_s = state_r;
    timeout_s    = (gap_r == GAP_LAST) && !rx_valid;
    hdr_n_s      = {count_r[19:8], rx_data};
    case (state_r)
      IDLE: begin
        if (start) state_next_s = SYNC;
        else       state_next_s = IDLE;
      end
      SYNC: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_next_s = HDR0;
        else if (timeout_s)                     state_next_s = ERROR;
        else                                    state_next_s = SYNC;
      end
      HDR0, HDR1: begin
        if (rx_valid)       state_next_s = (state_r == HDR0) ? HDR1 : HDR2;
        else if (timeout_s) state_next_s = ERROR;
        else                state_next_s = state_r;
      end
      HDR2: begin
        if (rx_valid) begin
          if ((hdr_n_s == 20'd0) || (hdr_n_s > MAX_N)) state_next_s = ERROR;
          else                                         state_next_s = DATA;
        end else if (timeout_s) begin
          state_next_s = ERROR;
        end else begin
          state_next_s = HDR2;
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (index_r == (count_r - 20'd1)) state_next_s = CHECK;
          else                              state_next_s = DATA;
        end else if (timeout_s) begin
          state_next_s = ERROR;
        end else begin
          state_next_s = DATA;
        end
      end
      CHECK: begin
        if (rx_valid)       state_next_s = (rx_data == xor_r) ? DONE : ERROR;
        else if (timeout_s) state_next_s = ERROR;
        else                state_next_s = CHECK;
      end
      DONE, ERROR: begin
        if (start) state_next_s = SYNC;
        else       state_next_s = state_r;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Status flags; error follows the ERROR state so a start out of ERROR clears it.
  always_ff @(posedge pclk) begin
    if (rst) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      busy_r  <= is_busy(state_next_s);
      done_r  <= (state_r == CHECK) && (state_next_s == DONE);
      error_r <= (state_next_s == ERROR);
    end
  end

  // Byte-gap counter, idle at zero outside an active frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      gap_r <= '0;
    end else if (rx_valid || !is_busy(state_r)) begin
      gap_r <= '0;
    end else begin
      gap_r <= gap_r + GAP_W'(1);
    end
  end

  // Header capture, pixel writes and checksum accumulation.
  always_ff @(posedge pclk) begin
    if (rst) begin
      count_r   <= 20'd0;
      index_r   <= 20'd0;
      xor_r     <= 8'd0;
      wr_addr_r <= 20'd0;
      wr_data_r <= 6'd0;
      wr_en_r   <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      if (rx_valid) begin
        case (state_r)
          HDR0: count_r <= {rx_data[3:0], 16'h0000};
          HDR1: count_r[15:8] <= rx_data;
          HDR2: begin
            count_r[7:0] <= rx_data;
            index_r      <= 20'd0;
            xor_r        <= 8'd0;
          end
          DATA: begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= index_r;
            wr_data_r <= rx_data[5:0];
            xor_r     <= xor_fold(xor_r, rx_data);
            if (state_next_s == DATA) index_r <= index_r + 20'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign wr_en   = wr_en_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign error   = error_r;

endmodule

// File: tb/tb_menu_loader.sv
// Directed bench for menu_loader: frame loads, header rejects, checksum
// failure and recovery, byte-gap timeout and mid-frame reset.
module tb_menu_loader;

  logic        pclk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [19:0] wr_addr;
  logic [5:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        error;

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [25:0] wlog[$];
  logic [7:0]  stim[$];

  menu_loader #(
    .SYNC_BYTE(8'hA5),
    .MAX_PIXELS(104796),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 pclk = ~pclk;

  // Record every write and done pulse mid-cycle.
  always @(negedge pclk) begin
    if (wr_en) wlog.push_back({wr_addr, wr_data});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [19:0] a, input logic [5:0] d);
    logic [25:0] got;
    got = (wlog.size() > i) ? wlog[i] : 26'h3FFFFFF;
    check(tag, 32'(got), 32'({a, d}));
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_start();
    wlog.delete();
    done_cnt = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    cyc();
  endtask

  task automatic send_stim();
    foreach (stim[i]) send_byte(stim[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    cyc(); cyc();
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_wr_en",   32'(wr_en),   32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_error",   32'(error),   32'd0);
    rst = 1'b0;
    cyc();

    // Basic three-pixel frame
    pulse_start();
    check("f1_busy", 32'(busy), 32'd1);
    stim = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h01, 8'h02, 8'h3F, 8'h3C};
    send_stim();
    cyc(); cyc(); cyc();
    check("f1_nwr", 32'(wlog.size()), 32'd3);
    chk_wr("f1_wr0", 0, 20'd0, 6'h01);
    chk_wr("f1_wr1", 1, 20'd1, 6'h02);
    chk_wr("f1_wr2", 2, 20'd2, 6'h3F);
    check("f1_done", 32'(done_cnt), 32'd1);
    check("f1_error", 32'(error), 32'd0);
    check("f1_busy_end", 32'(busy), 32'd0);
    check("f1_addr_hold", 32'(wr_addr), 32'd2);

    // Junk before sync, top data bits dropped from pixel
    pulse_start();
    stim = '{8'h11, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hC5, 8'hC5};
    send_stim();
    cyc();
    check("f2_nwr", 32'(wlog.size()), 32'd1);
    chk_wr("f2_wr0", 0, 20'd0, 6'h05);
    check("f2_done", 32'(done_cnt), 32'd1);
    check("f2_error", 32'(error), 32'd0);

    // Oversized and zero pixel counts
    pulse_start();
    stim = '{8'hA5, 8'h0F, 8'hFF, 8'hFF};
    send_stim();
    check("big_error", 32'(error), 32'd1);
    check("big_busy", 32'(busy), 32'd0);
    check("big_nwr", 32'(wlog.size()), 32'd0);
    pulse_start();
    check("clr_error", 32'(error), 32'd0);
    stim = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_stim();
    check("zero_error", 32'(error), 32'd1);
    check("zero_nwr", 32'(wlog.size()), 32'd0);

    // Bad checksum, then recovery with a good frame
    pulse_start();
    stim = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h10, 8'h20, 8'hFF};
    send_stim();
    check("bad_nwr", 32'(wlog.size()), 32'd2);
    chk_wr("bad_wr1", 1, 20'd1, 6'h20);
    check("bad_error", 32'(error), 32'd1);
    check("bad_done", 32'(done_cnt), 32'd0);
    pulse_start();
    check("rec_clr", 32'(error), 32'd0);
    stim = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h07, 8'hC8, 8'hCF};
    send_stim();
    chk_wr("rec_wr0", 0, 20'd0, 6'h07);
    chk_wr("rec_wr1", 1, 20'd1, 6'h08);
    check("rec_done", 32'(done_cnt), 32'd1);
    check("rec_error", 32'(error), 32'd0);

    // Byte-gap timeout after first data byte: 100 cycles
    pulse_start();
    stim = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h11};
    send_stim();
    for (int i = 0; i < 98; i++) cyc();
    check("to_early", 32'(error), 32'd0);
    cyc();
    check("to_hit", 32'(error), 32'd1);
    check("to_nwr", 32'(wlog.size()), 32'd1);

    // Reset during DATA aborts the frame
    pulse_start();
    stim = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'h01, 8'h02};
    send_stim();
    rst = 1'b1; rx_data = 8'h03; rx_valid = 1'b1;
    cyc();
    rst = 1'b0; rx_valid = 1'b0;
    check("mr_wr_en",   32'(wr_en),   32'd0);
    check("mr_wr_addr", 32'(wr_addr), 32'd0);
    check("mr_wr_data", 32'(wr_data), 32'd0);
    check("mr_busy",    32'(busy),    32'd0);
    stim = '{8'h04, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h3F};
    send_stim();
    check("mr_nwr", 32'(wlog.size()), 32'd2);
    check("mr_nodone", 32'(done_cnt), 32'd0);
    pulse_start();
    stim = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h3F};
    send_stim();
    chk_wr("mr_wr0", 0, 20'd0, 6'h3F);
    check("mr_done", 32'(done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
